// File: rtl/maxpool_layer_sched.sv
// maxpool_layer_sched: per-layer window scheduler around the maxpool AXIS wrapper.
// A descriptor opens one layer. The scheduler holds the maxpool mode steady for
// that layer and forwards only the beats that belong to it in each direction.
// It regenerates tlast from its own beat counters and raises sticky flags when
// the stream framing or the descriptor is inconsistent.
module maxpool_layer_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int CONV_CORES = 1,
  parameter int CNT_WIDTH  = 20
) (
  input  logic                             aclk,
  input  logic                             aresetn,

  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic                             cfg_mode,
  input  logic [CNT_WIDTH-1:0]             cfg_in_beats,
  input  logic [CNT_WIDTH-1:0]             cfg_out_beats,

  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [DATA_WIDTH*CONV_CORES-1:0] s_axis_tdata,

  output logic                             mp_s_axis_tvalid,
  input  logic                             mp_s_axis_tready,
  output logic                             mp_s_axis_tlast,
  output logic [DATA_WIDTH*CONV_CORES-1:0] mp_s_axis_tdata,
  output logic                             mp_max_mode,

  input  logic                             mp_m_axis_tvalid,
  output logic                             mp_m_axis_tready,
  input  logic                             mp_m_axis_tlast,
  input  logic [DATA_WIDTH*CONV_CORES-1:0] mp_m_axis_tdata,

  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [DATA_WIDTH*CONV_CORES-1:0] m_axis_tdata,

  output logic                             busy,
  output logic                             layer_done,
  output logic                             err_tlast,
  output logic                             err_cfg
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] in_beats;
  logic [CNT_WIDTH-1:0] out_beats;
  logic [CNT_WIDTH-1:0] in_cnt;
  logic [CNT_WIDTH-1:0] out_cnt;

  logic in_open;
  logic out_open;
  logic in_hs;
  logic out_hs;
  logic in_last;
  logic out_last;
  logic cfg_hs;
  logic cfg_bad;

  // Both windows are also closed while reset is held, so that nothing is accepted mid-abort.
  always_comb begin
    in_open  = aresetn && (state == ST_RUN) && (in_cnt < in_beats);
    out_open = aresetn && ((state == ST_RUN) || (state == ST_DRAIN)) && (out_cnt < out_beats);
    in_last  = (in_cnt == in_beats - CNT_ONE);
    out_last = (out_cnt == out_beats - CNT_ONE);
    in_hs    = s_axis_tvalid && mp_s_axis_tready && in_open;
    out_hs   = mp_m_axis_tvalid && m_axis_tready && out_open;
    cfg_hs   = cfg_valid && cfg_ready;
    cfg_bad  = (cfg_in_beats == CNT_ZERO) || (cfg_out_beats == CNT_ZERO);
  end

  // Stream gating: data passes straight through, and tlast is rebuilt from the counters.
  always_comb begin
    mp_s_axis_tvalid = s_axis_tvalid && in_open;
    s_axis_tready    = mp_s_axis_tready && in_open;
    mp_s_axis_tdata  = s_axis_tdata;
    mp_s_axis_tlast  = in_open && in_last;
    m_axis_tvalid    = mp_m_axis_tvalid && out_open;
    mp_m_axis_tready = m_axis_tready && out_open;
    m_axis_tdata     = mp_m_axis_tdata;
    m_axis_tlast     = out_open && out_last;
  end

  // Next-state and status decode for the layer sequencer.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    busy       = 1'b0;
    layer_done = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = aresetn;
        if (cfg_hs && !cfg_bad) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (in_hs && in_last) begin
          if ((out_cnt == out_beats) || (out_hs && out_last)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (out_hs && out_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        layer_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Descriptor latch, beat counters and sticky error flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mp_max_mode <= 1'b0;
      in_beats    <= '0;
      out_beats   <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      err_tlast   <= 1'b0;
      err_cfg     <= 1'b0;
    end else if (cfg_hs) begin
      if (cfg_bad) begin
        err_cfg <= 1'b1;
      end else begin
        mp_max_mode <= cfg_mode;
        in_beats    <= cfg_in_beats;
        out_beats   <= cfg_out_beats;
        in_cnt      <= '0;
        out_cnt     <= '0;
        err_tlast   <= 1'b0;
        err_cfg     <= 1'b0;
      end
    end else begin
      if (in_hs) begin
        in_cnt <= in_cnt + CNT_ONE;
        if (s_axis_tlast != in_last) begin
          err_tlast <= 1'b1;
        end
      end
      if (out_hs) begin
        out_cnt <= out_cnt + CNT_ONE;
        if (mp_m_axis_tlast != out_last) begin
          err_tlast <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/maxpool_layer_sched.md
Name: maxpool_layer_sched

Overview:
- Per-layer scheduler that sits between the conv output stream and the maxpool AXIS wrapper, and between that wrapper and the downstream consumer.
- Accepts one layer descriptor (mode, input beat count, output beat count), then holds max_mode stable for the whole layer.
- Gates both streams to the layer window and regenerates tlast from the counters.
- Signals layer completion and flags framing errors, so a layer never mixes with the next and mode never changes mid-frame.

Parameters:
- DATA_WIDTH, 16, bits per conv core word.
- CONV_CORES, 1, cores packed per beat; stream width is DATA_WIDTH*CONV_CORES.
- CNT_WIDTH, 20, width of beat counters and descriptor counts.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  synchronous active-low reset.
- cfg_valid  in  1  descriptor valid.
- cfg_ready  out  1  descriptor accepted when cfg_valid&cfg_ready.
- cfg_mode  in  1  0: no maxpool, 1: maxpool.
- cfg_in_beats  in  CNT_WIDTH  input beats in layer.
- cfg_out_beats  in  CNT_WIDTH  output beats expected from maxpool.
- s_axis_tvalid/s_axis_tready/s_axis_tlast  in/out/in  1  upstream stream handshake and frame end.
- s_axis_tdata  in  DATA_WIDTH*CONV_CORES  upstream data.
- mp_s_axis_tvalid/mp_s_axis_tready/mp_s_axis_tlast  out/in/out  1  to maxpool slave port.
- mp_s_axis_tdata  out  DATA_WIDTH*CONV_CORES  to maxpool.
- mp_max_mode  out  1  latched mode to maxpool.
- mp_m_axis_tvalid/mp_m_axis_tready/mp_m_axis_tlast  in/out/in  1  from maxpool master port.
- mp_m_axis_tdata  in  DATA_WIDTH*CONV_CORES  from maxpool.
- m_axis_tvalid/m_axis_tready/m_axis_tlast  out/in/out  1  downstream stream.
- m_axis_tdata  out  DATA_WIDTH*CONV_CORES  downstream data.
- busy  out  1  high in RUN/DRAIN.
- layer_done  out  1  one-cycle pulse at layer end.
- err_tlast  out  1  sticky framing error.
- err_cfg  out  1  sticky bad-descriptor error.

Behaviour:

Reset values:
- State IDLE; counters 0; mp_max_mode 0; layer_done 0; err_tlast 0; err_cfg 0; busy 0.
- All gated valids and readies 0.
- Reset mid-layer aborts immediately. No further beats are forwarded. Maxpool internal state is reset by its own aresetn, which is driven from the same net.

States:
- IDLE: cfg_ready=1. On cfg handshake:
  - If cfg_in_beats==0 or cfg_out_beats==0: set err_cfg, stay IDLE.
  - Else: latch mode and counts, clear err_tlast and err_cfg, zero in_cnt and out_cnt, go to RUN.
- RUN: input and output paths are both open.
  - When the last input beat handshakes: if out_cnt has already reached out_beats, or is reaching it in the same cycle, go to DONE; else go to DRAIN.
- DRAIN: input path closed, output path open. When the last output beat handshakes, go to DONE.
- DONE: layer_done=1 for exactly one cycle, then IDLE. cfg_ready=0 in DONE.

Input path:
- The path is combinational, with zero latency.
- mp_s_axis_tvalid = s_axis_tvalid & in_open.
- s_axis_tready = mp_s_axis_tready & in_open.
- in_open = (RUN and in_cnt<in_beats).
- tdata passes straight through.
- mp_s_axis_tlast is forced to 1 on beat in_beats-1, and is 0 otherwise.
- in_cnt increments on each mp_s handshake.
- If s_axis_tlast differs from the generated tlast on any handshake, set err_tlast. The beat is still forwarded with the generated tlast.

Output path:
- out_open = (RUN or DRAIN) and out_cnt<out_beats.
- m_axis_tvalid = mp_m_axis_tvalid & out_open.
- mp_m_axis_tready = m_axis_tready & out_open.
- m_axis_tlast is 1 on beat out_beats-1 only.
- A maxpool tlast that mismatches the generated tlast sets err_tlast.
- Once out_cnt==out_beats, the output path closes; excess maxpool output is back-pressured.

Mode and counters:
- mp_max_mode changes only on a cfg handshake. It is stable from the first RUN cycle to the end of DONE.
- Counters saturate at their target and never wrap.
- Counter width is CNT_WIDTH unsigned; comparisons are unsigned.

Simultaneous events:
- Last input and last output in the same cycle: RUN goes directly to DONE.
- cfg_valid outside IDLE is ignored and held off by cfg_ready=0.
- Upstream valid while IDLE is stalled, not dropped.

Test Plan:
- Reset, then cfg mode=1, in=8, out=2. Send 8 beats 1..8 with tlast on beat 8; maxpool returns 2 beats. Required: mp_s tlast on beat 8, m tlast on beat 2, layer_done pulse one cycle later, mp_max_mode=1 throughout, err flags 0.
- cfg mode=0, in=out=4, with random m_axis_tready toggling. Required: 4 beats out in order, no loss or duplication, and layer_done only after the 4th output handshake.
- cfg in=6 with upstream tlast on beat 3. Required: err_tlast=1, all 6 beats forwarded, mp_s tlast only on beat 6.
- cfg in=0. Required: err_cfg=1, state stays IDLE, busy=0. The next valid cfg clears err_cfg.
- Assert aresetn low for one cycle during DRAIN at out_cnt=1. Required: all outputs return to reset values the next cycle, no layer_done, and cfg_ready=1 after release.
- Final output beat and final input beat handshake in the same cycle. Required: DONE is reached next cycle, skipping DRAIN, and a second cfg is accepted two cycles later.
